// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit. The MDU_MADD_EN build
// also uses the MDOpX sub-op codes declared here.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_MADD  = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [3:0] MDX_MADD  = 4'd0;
    localparam logic [3:0] MDX_MADDU = 4'd1;
    localparam logic [3:0] MDX_MSUB  = 4'd2;

    // The counter holds N-1, so clog2(N) bits suffice; keep at least one bit.
    function automatic int cnt_width(input int mult_cycles, input int div_cycles);
        int mx;
        mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return (mx > 1) ? $clog2(mx) : 1;
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit result generator for mult/multu/div/divu.
// With MDU_MADD_EN defined it also forms the madd/maddu/msub accumulations.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  op_i,
`ifdef MDU_MADD_EN
    input  logic [3:0]  opx_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
`endif
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] res_hi_o,
    output logic [31:0] res_lo_o,
    output logic        div_zero_o
);
    logic [63:0] smul;
    logic [63:0] umul;
    logic        sdiv;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;
`ifdef MDU_MADD_EN
    logic [63:0] acc;
`endif

    always_comb begin
        // Low 64 bits of the product of sign-extended operands are the signed product.
        smul = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
        umul = {32'b0, a_i} * {32'b0, b_i};

        // Signed division runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        sdiv  = (op_i == MD_DIV);
        neg_q = sdiv && (a_i[31] ^ b_i[31]);
        neg_r = sdiv && a_i[31];
        dvd   = (sdiv && a_i[31]) ? -a_i : a_i;
        dvs   = (sdiv && b_i[31]) ? -b_i : b_i;
        if (b_i == 32'd0) begin
            dvs = 32'd1;
        end
        quo = dvd / dvs;
        rem = dvd % dvs;
        if (neg_q) begin
            quo = -quo;
        end
        if (neg_r) begin
            rem = -rem;
        end

        div_zero_o = ((op_i == MD_DIV) || (op_i == MD_DIVU)) && (b_i == 32'd0);

`ifdef MDU_MADD_EN
        acc = {hi_i, lo_i};
`endif
        case (op_i)
            MD_MULT:         {res_hi_o, res_lo_o} = smul;
            MD_MULTU:        {res_hi_o, res_lo_o} = umul;
            MD_DIV, MD_DIVU: {res_hi_o, res_lo_o} = {rem, quo};
`ifdef MDU_MADD_EN
            MD_MADD: begin
                if (opx_i == MDX_MADDU) begin
                    {res_hi_o, res_lo_o} = acc + umul;
                end else if (opx_i == MDX_MSUB) begin
                    {res_hi_o, res_lo_o} = acc - smul;
                end else begin
                    {res_hi_o, res_lo_o} = acc + smul;
                end
            end
`endif
            default:         {res_hi_o, res_lo_o} = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit holding HI/LO with fixed-latency Busy window.
// Define MDU_MADD_EN to enable MDOp 7 (madd family) and the MDOpX port.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
`ifdef MDU_MADD_EN
    input  logic [3:0]  MDOpX,
`endif
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HILOSel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDout
);
    localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      hi_q;
    logic [31:0]      hi_d;
    logic [31:0]      lo_q;
    logic [31:0]      lo_d;
    logic [31:0]      pend_hi_q;
    logic [31:0]      pend_lo_q;
    logic             pend_keep_q;
    logic             is_mul;
    logic             is_div;
    logic             accept;
    logic             commit;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             div_zero;

    always_comb begin
        is_mul = (MDOp == MD_MULT) || (MDOp == MD_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (MDOp == MD_MADD);
`endif
        is_div = (MDOp == MD_DIV) || (MDOp == MD_DIVU);
        accept = Start && (state_q == IDLE) && (is_mul || is_div);
        commit = (state_q == RUN) && (cnt_q == '0);
    end

    mdu_calc u_calc (
        .op_i       (MDOp),
`ifdef MDU_MADD_EN
        .opx_i      (MDOpX),
        .hi_i       (hi_q),
        .lo_i       (lo_q),
`endif
        .a_i        (A),
        .b_i        (B),
        .res_hi_o   (res_hi),
        .res_lo_o   (res_lo),
        .div_zero_o (div_zero)
    );

    // State register: reset clears HI/LO and aborts any in-flight operation.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Result is captured at the accepting edge so operands need not be held.
    always_ff @(posedge Clk) begin
        if (accept) begin
            pend_hi_q   <= res_hi;
            pend_lo_q   <= res_lo;
            pend_keep_q <= div_zero;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (MDOp == MD_MTHI) begin
                    hi_d = A;
                end
                if (MDOp == MD_MTLO) begin
                    lo_d = A;
                end
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            RUN: begin
                if (commit) begin
                    state_d = IDLE;
                    if (!pend_keep_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy  = (state_q == RUN);
        HI    = hi_q;
        LO    = lo_q;
        MDout = HILOSel ? hi_q : lo_q;
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: vector table, corner sequences, random ops vs model.
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        HILOSel;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDout;
`ifdef MDU_MADD_EN
    logic [3:0]  MDOpX = 4'd0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .MDOp    (MDOp),
`ifdef MDU_MADD_EN
        .MDOpX   (MDOpX),
`endif
        .A       (A),
        .B       (B),
        .HILOSel (HILOSel),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO),
        .MDout   (MDout)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          ecyc;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [2:0] op, input logic [31:0] val);
        @(negedge Clk);
        Start = 1'b0;
        MDOp  = op;
        A     = val;
        @(negedge Clk);
        MDOp  = MD_NONE;
    endtask

    // Issue one Start pulse, scramble operands afterwards, count Busy cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        @(negedge Clk);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(negedge Clk);
        Start = 1'b0;
        MDOp  = MD_NONE;
        A     = $urandom;
        B     = $urandom;
        cyc   = 0;
        while (Busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge Clk);
        end
    endtask

    // Reference: architectural arithmetic on 64-bit integers.
    task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          inout logic [31:0] hi, inout logic [31:0] lo);
        longint          sa;
        longint          sb;
        longint          p;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            MD_MULT:  begin p  = sa * sb; hi = p[63:32];  lo = p[31:0];  end
            MD_MULTU: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
            MD_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            MD_DIVU:  if (b != 0) begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
            MD_MTHI:  hi = a;
            MD_MTLO:  lo = a;
            default:  ;
        endcase
    endtask

    initial begin
        int          cyc;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] mhi;
        logic [31:0] mlo;
        int          sel;

        vt[0] = '{MD_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, MC};
        vt[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MC};
        vt[2] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vt[3] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       DC};
        vt[4] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DC};
        vt[5] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
        vt[6] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
        vt[7] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};

        Reset   = 1'b0;
        Start   = 1'b0;
        MDOp    = MD_NONE;
        A       = 32'h0;
        B       = 32'h0;
        HILOSel = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, cyc);
            check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vt[i].ecyc));
            check($sformatf("vec%0d_hi", i), HI, vt[i].ehi);
            check($sformatf("vec%0d_lo", i), LO, vt[i].elo);
        end

        // mthi/mtlo in IDLE, MDout select, then divide by zero leaves HI/LO intact.
        write_reg(MD_MTHI, 32'h11);
        write_reg(MD_MTLO, 32'h22);
        HILOSel = 1'b1;
        #1 check("mdout_hi", MDout, 32'h11);
        HILOSel = 1'b0;
        #1 check("mdout_lo", MDout, 32'h22);
        run_op(MD_DIVU, 32'd5, 32'd0, cyc);
        check("divz_cycles", 32'(cyc), 32'(DC));
        check("divz_hi", HI, 32'h11);
        check("divz_lo", LO, 32'h22);

        // Start with a non-computing op has no effect.
        @(negedge Clk);
        Start = 1'b1;
        MDOp  = MD_NONE;
        @(negedge Clk);
`ifndef MDU_MADD_EN
        MDOp  = MD_MADD;
        @(negedge Clk);
`endif
        Start = 1'b0;
        MDOp  = MD_NONE;
        check("noop_busy", 32'(Busy), 32'd0);
        check("noop_hi", HI, 32'h11);
        check("noop_lo", LO, 32'h22);

        // mthi during RUN is ignored, second Start during Busy does not retrigger.
        @(negedge Clk);
        Start = 1'b1;
        MDOp  = MD_MULT;
        A     = 32'h12345678;
        B     = 32'h00000100;
        @(negedge Clk);
        Start = 1'b0;
        MDOp  = MD_NONE;
        cyc   = 0;
        while (Busy === 1'b1 && cyc < 200) begin
            cyc++;
            Start = 1'b0;
            MDOp  = MD_NONE;
            if (cyc == 2) begin
                MDOp = MD_MTHI;
                A    = 32'hDEAD;
            end
            if (cyc == 3) begin
                Start = 1'b1;
                MDOp  = MD_MULT;
                A     = 32'd7;
                B     = 32'd7;
            end
            @(negedge Clk);
        end
        Start = 1'b0;
        MDOp  = MD_NONE;
        check("run_cycles", 32'(cyc), 32'(MC));
        check("run_hi", HI, 32'h00000012);
        check("run_lo", LO, 32'h34567800);
        @(negedge Clk);
        check("run_noretrig", 32'(Busy), 32'd0);

        // Reset in Busy cycle 3 aborts the divide.
        write_reg(MD_MTHI, 32'h55);
        write_reg(MD_MTLO, 32'h66);
        @(negedge Clk);
        Start = 1'b1;
        MDOp  = MD_DIV;
        A     = 32'd100;
        B     = 32'd3;
        @(negedge Clk);
        Start = 1'b0;
        MDOp  = MD_NONE;
        @(negedge Clk);
        @(negedge Clk);
        check("abort_busy_c3", 32'(Busy), 32'd1);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        repeat (12) @(negedge Clk);
        check("abort_late_busy", 32'(Busy), 32'd0);
        check("abort_late_hi", HI, 32'd0);
        check("abort_late_lo", LO, 32'd0);

        // Random ops against the model, which starts from the post-reset state.
        mhi = 32'd0;
        mlo = 32'd0;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(1, 6));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 9));
            ref_op(op, a, b, mhi, mlo);
            if (op == MD_MTHI || op == MD_MTLO) begin
                write_reg(op, a);
            end else begin
                run_op(op, a, b, cyc);
                check($sformatf("rnd%0d_cycles", i), 32'(cyc),
                      (op == MD_MULT || op == MD_MULTU) ? 32'(MC) : 32'(DC));
            end
            check($sformatf("rnd%0d_hi", i), HI, mhi);
            check($sformatf("rnd%0d_lo", i), LO, mlo);
            HILOSel = 1'($urandom_range(0, 1));
            #1 check($sformatf("rnd%0d_mdout", i), MDout, HILOSel ? mhi : mlo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
